// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types for the fetch/data memory bus arbiter
package mem_bus_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_BE_W-1:0]   be;
    } mem_req_t;

    // Instruction fetches are always full-word reads.
    function automatic mem_req_t make_fetch_req(input logic [ARB_ADDR_W-1:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.addr  = addr;
        r.wdata = '0;
        r.be    = '1;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - busy-cycle counter with expiry compare for the bus arbiter
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th busy cycle of a transaction.
    assign o_expired = i_run && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin fetch/data memory bus arbiter (optional watchdog: ARB_TIMEOUT_EN)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                bus_err,
    output logic                stall
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    mem_req_t          r_req;
    logic              r_gnt_d;
    logic              r_last_d;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant;
    logic              w_grant_d;
    logic              w_busy;
    logic              w_finish;
    logic              w_expired;
    logic [DATA_W-1:0] w_rdata;

    assign w_busy   = (r_state == ARB_BUSY_I) || (r_state == ARB_BUSY_D);
    assign w_finish = w_busy && (bus_ack || w_expired);
    assign w_rdata  = bus_ack ? bus_rdata : '0;

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // On a tie the requester that was not served last wins.
                if (d_req && (!i_req || !r_last_d)) begin
                    w_next    = ARB_BUSY_D;
                    w_grant   = 1'b1;
                    w_grant_d = 1'b1;
                end else if (i_req) begin
                    w_next  = ARB_BUSY_I;
                    w_grant = 1'b1;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (bus_ack || w_expired) begin
                    w_next = ARB_RESP;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ARB_IDLE;
            r_req     <= '0;
            r_gnt_d   <= 1'b0;
            r_last_d  <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt_d <= w_grant_d;
                r_req   <= w_grant_d ? '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be}
                                     : make_fetch_req(i_addr);
            end
            if (w_finish) begin
                if (!r_gnt_d) begin
                    r_i_rdata <= w_rdata;
                end else if (!r_req.we) begin
                    r_d_rdata <= w_rdata;
                end
            end
            if (r_state == ARB_RESP) begin
                r_last_d <= r_gnt_d;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic r_bus_err;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_grant),
        .i_run    (w_busy),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_err <= 1'b0;
        end else if (w_busy && w_expired && !bus_ack) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_expired = 1'b0;
    assign bus_err   = 1'b0;
`endif

    assign bus_req   = w_busy;
    assign bus_we    = r_req.we;
    assign bus_addr  = r_req.addr;
    assign bus_wdata = r_req.wdata;
    assign bus_be    = r_req.be;
    assign i_done    = (r_state == ARB_RESP) && !r_gnt_d;
    assign d_done    = (r_state == ARB_RESP) && r_gnt_d;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall     = (i_req || d_req) && !(i_done || d_done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (transaction model + directed vectors)
module tb_mem_bus_arbiter;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err;
    logic        stall;

    int n_chk  = 0;
    int n_fail = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_done(d_done), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: owner 0 = none, 1 = fetch, 2 = data.
    int          m_owner = 0;
    int          m_done  = 0;
    int          m_busy_n = 0;
    bit          m_last_d = 1'b0;
    bit          m_err = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_i_rd = '0, m_d_rd = '0;
    logic [3:0]  m_be = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = 0; m_done = 0; m_busy_n = 0; m_last_d = 1'b0; m_err = 1'b0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_i_rd = '0; m_d_rd = '0;
        end else if (m_owner != 0) begin
            bit expire;
            expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
            expire = (m_busy_n == TO - 1);
`endif
            if (bus_ack || expire) begin
                if (m_owner == 1) m_i_rd = bus_ack ? bus_rdata : 32'h0;
                else if (!m_we)   m_d_rd = bus_ack ? bus_rdata : 32'h0;
                if (!bus_ack) m_err = 1'b1;
                m_done  = m_owner;
                m_owner = 0;
            end else begin
                m_busy_n++;
            end
        end else if (m_done != 0) begin
            m_last_d = (m_done == 2);
            m_done   = 0;
        end else if (d_req && (!i_req || !m_last_d)) begin
            m_owner = 2; m_busy_n = 0;
            m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
        end else if (i_req) begin
            m_owner = 1; m_busy_n = 0;
            m_we = 1'b0; m_addr = i_addr; m_wdata = 32'h0; m_be = 4'hF;
        end
    end

    always @(negedge clk) begin
        bit e_id, e_dd;
        e_id = (m_done == 1);
        e_dd = (m_done == 2);
        chk("m_bus_req", bus_req, m_owner != 0);
        if (m_owner != 0) begin
            chk("m_bus_we", bus_we, m_we);
            chk("m_bus_addr", bus_addr, m_addr);
            chk("m_bus_wdata", bus_wdata, m_wdata);
            chk("m_bus_be", bus_be, m_be);
        end
        chk("m_i_done", i_done, e_id);
        chk("m_d_done", d_done, e_dd);
        chk("m_i_rdata", i_rdata, m_i_rd);
        chk("m_d_rdata", d_rdata, m_d_rd);
        chk("m_bus_err", bus_err, m_err);
        chk("m_stall", stall, (i_req | d_req) & ~(e_id | e_dd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    endtask

    initial begin
        int pulses;
        int seen;
        rst = 1'b0;
        repeat (3) tick();
        chk("reset bus_req", bus_req, 0);
        chk("reset d_done", d_done, 0);
        chk("reset bus_addr", bus_addr, 0);
        chk("reset d_rdata", d_rdata, 0);
        chk("reset bus_err", bus_err, 0);
        rst = 1'b1;
        tick();

        // Single load, ack at cycle 3.
        start_d(1'b0, 32'h100, 32'h0, 4'hF);
        @(negedge clk); chk("t1 stall c0", stall, 1); chk("t1 bus_req c0", bus_req, 0);
        tick(); @(negedge clk); chk("t1 bus_req c1", bus_req, 1); chk("t1 addr c1", bus_addr, 32'h100);
        tick(); tick();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk); chk("t1 stall c3", stall, 1);
        tick(); bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("t1 d_done c4", d_done, 1); chk("t1 d_rdata", d_rdata, 32'hDEADBEEF);
        chk("t1 bus_req c4", bus_req, 0); chk("t1 stall c4", stall, 0);
        tick();

        // Store: fields exact and stable; d_rdata unchanged.
        start_d(1'b1, 32'h200, 32'h12345678, 4'h3);
        tick(); @(negedge clk);
        chk("st we", bus_we, 1); chk("st addr", bus_addr, 32'h200);
        chk("st wdata", bus_wdata, 32'h12345678); chk("st be", bus_be, 4'h3);
        tick(); tick();
        @(negedge clk); chk("st addr stable", bus_addr, 32'h200); chk("st be stable", bus_be, 4'h3);
        bus_ack = 1'b1; bus_rdata = 32'hAAAAAAAA;
        tick(); bus_ack = 1'b0;
        @(negedge clk); chk("st d_done", d_done, 1); chk("st d_rdata kept", d_rdata, 32'hDEADBEEF);
        tick(); d_req = 1'b0;

        // Reset during BUSY_D.
        start_d(1'b0, 32'h180, 32'h0, 4'hF);
        tick(); @(negedge clk); chk("rs busy", bus_req, 1);
        tick(); rst = 1'b0; d_req = 1'b0; #1;
        chk("rs bus_req drop", bus_req, 0);
        tick(); rst = 1'b1;
        tick(); tick();

        // Tie after reset: data first, then alternation.
        i_req = 1'b1; i_addr = 32'h40;
        start_d(1'b0, 32'h300, 32'h0, 4'hF);
        tick(); @(negedge clk); chk("tie1 addr", bus_addr, 32'h300); chk("tie1 we", bus_we, 0);
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        tick(); bus_ack = 1'b0;
        @(negedge clk); chk("tie1 d_done", d_done, 1); chk("tie1 i_done", i_done, 0);
        tick(); d_addr = 32'h304;
        tick(); @(negedge clk);
        chk("tie2 addr", bus_addr, 32'h40); chk("tie2 be", bus_be, 4'hF); chk("tie2 we", bus_we, 0);
        bus_ack = 1'b1; bus_rdata = 32'h22222222;
        tick(); bus_ack = 1'b0;
        @(negedge clk); chk("tie2 i_done", i_done, 1); chk("tie2 i_rdata", i_rdata, 32'h22222222);
        tick(); i_req = 1'b0;
        tick(); @(negedge clk); chk("tie3 addr", bus_addr, 32'h304);
        bus_ack = 1'b1; bus_rdata = 32'h33333333;
        tick(); bus_ack = 1'b0;
        tick(); d_req = 1'b0;

        // Request dropped mid-BUSY still completes with one pulse.
        start_d(1'b0, 32'h400, 32'h0, 4'hF);
        tick(); d_req = 1'b0;
        tick(); bus_ack = 1'b1; bus_rdata = 32'h44444444;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick(); bus_ack = 1'b0;
            @(negedge clk); if (d_done) pulses++;
        end
        chk("drop pulses", pulses, 1);
        chk("drop d_rdata", d_rdata, 32'h44444444);

        // Ack while idle is ignored.
        bus_ack = 1'b1; bus_rdata = 32'h99999999;
        tick(); tick(); bus_ack = 1'b0;
        @(negedge clk); chk("idle ack d_done", d_done, 0); chk("idle ack d_rdata", d_rdata, 32'h44444444);
        tick();

        // Unacknowledged load.
        start_d(1'b0, 32'h500, 32'h0, 4'hF);
        seen = 0;
        for (int n = 1; n <= 80 && seen == 0; n++) begin
            tick();
            @(negedge clk); if (d_done) seen = n;
        end
`ifdef ARB_TIMEOUT_EN
        chk("to done cycle", seen, TO + 1);
        chk("to d_rdata", d_rdata, 0);
        chk("to bus_err", bus_err, 1);
        tick(); d_req = 1'b0;
        repeat (4) tick();
        @(negedge clk); chk("to bus_err sticky", bus_err, 1);
`else
        chk("no-to no done", seen, 0);
        chk("no-to still busy", bus_req, 1);
        tick(); bus_ack = 1'b1; bus_rdata = 32'h55555555;
        tick(); bus_ack = 1'b0;
        @(negedge clk); chk("no-to d_done", d_done, 1); chk("no-to d_rdata", d_rdata, 32'h55555555);
        tick(); d_req = 1'b0;
`endif
        tick(); rst = 1'b0; #1;
        chk("final bus_err", bus_err, 0);
        tick(); rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
